// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory request/acknowledge port between the IF stage and instruction memory.
interface instr_fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch_stage.sv
// IF stage: PC, req/ack instruction fetch, IF/ID register with one-entry skid buffer,
// and branch/jump redirect that flushes IF/ID and drains a pending fetch.
//
//   state | meaning
//   FETCH | request outstanding at pc; ack loads IF/ID or the skid buffer
//   SKID  | skid buffer full, no request; empties into IF/ID when stall drops
//   DRAIN | request to a pre-redirect address outstanding; its ack is dropped
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clock,
    input  logic                       reset,
    instr_fetch_stage_if.master        imem,
    input  logic                       stall,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       id_valid,
    output logic [31:0]                id_instr,
    output logic [31:0]                id_pc4,
    output logic [15:0]                id_imm
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        SKID  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] drain_addr, drain_addr_nxt;
    logic [31:0] skid_instr, skid_instr_nxt;
    logic [31:0] skid_pc4, skid_pc4_nxt;
    logic        id_valid_nxt;
    logic [31:0] id_instr_nxt, id_pc4_nxt;
    logic        req, ack;
    logic [31:0] pc_plus4;
    logic [1:0]  unused_rpc_lsb;

    // Gated by reset so no request is visible while the block is held in reset.
    assign req            = !reset && (state != SKID);
    assign ack            = req && imem.ack;
    assign imem.req       = req;
    assign imem.addr      = (state == DRAIN) ? drain_addr : pc;
    assign pc_plus4       = pc + 32'd4;
    assign id_imm         = id_instr[15:0];
    assign unused_rpc_lsb = redirect_pc[1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            drain_addr <= '0;
            skid_instr <= '0;
            skid_pc4   <= '0;
            id_valid   <= 1'b0;
            id_instr   <= '0;
            id_pc4     <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            drain_addr <= drain_addr_nxt;
            skid_instr <= skid_instr_nxt;
            skid_pc4   <= skid_pc4_nxt;
            id_valid   <= id_valid_nxt;
            id_instr   <= id_instr_nxt;
            id_pc4     <= id_pc4_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        drain_addr_nxt = drain_addr;
        skid_instr_nxt = skid_instr;
        skid_pc4_nxt   = skid_pc4;
        id_valid_nxt   = id_valid;
        id_instr_nxt   = id_instr;
        id_pc4_nxt     = id_pc4;

        if (redirect) begin
            pc_nxt       = {redirect_pc[31:2], 2'b00};
            id_valid_nxt = 1'b0;
            // An unanswered request must be drained; a redirect in DRAIN keeps the old address.
            if (req && !ack) begin
                state_nxt = DRAIN;
                if (state == FETCH) begin
                    drain_addr_nxt = pc;
                end
            end else begin
                state_nxt = FETCH;
            end
        end else begin
            if (id_valid && !stall) begin
                id_valid_nxt = 1'b0;
            end
            case (state)
                FETCH: begin
                    if (ack) begin
                        pc_nxt = pc_plus4;
                        if (!id_valid || !stall) begin
                            id_instr_nxt = imem.rdata;
                            id_pc4_nxt   = pc_plus4;
                            id_valid_nxt = 1'b1;
                        end else begin
                            skid_instr_nxt = imem.rdata;
                            skid_pc4_nxt   = pc_plus4;
                            state_nxt      = SKID;
                        end
                    end
                end
                SKID: begin
                    if (!stall) begin
                        id_instr_nxt = skid_instr;
                        id_pc4_nxt   = skid_pc4;
                        id_valid_nxt = 1'b1;
                        state_nxt    = FETCH;
                    end
                end
                DRAIN: begin
                    if (ack) begin
                        state_nxt = FETCH;
                    end
                end
                default: begin
                    state_nxt = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: a latency-configurable memory model feeds a
// scoreboard of accepted fetches that is compared against IF/ID as entries appear.
module tb_instr_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic [15:0] id_imm;

    instr_fetch_stage_if imem();

    instr_fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem        (imem),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc4      (id_pc4),
        .id_imm      (id_imm)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } sb_ent_t;

    sb_ent_t     sb_q[$];
    int          n_vec = 0;
    int          n_miscmp = 0;
    int          lat = 1;
    int          wait_cnt = 0;
    logic        spur = 1'b0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_data = '0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] prev_addr = '0;
    logic [31:0] held_instr = '0;
    logic [31:0] held_pc4 = '0;
    logic        draining = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic        prev_hold = 1'b0;
    logic        prev_rd = 1'b0;
    logic        prev_rst = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ovr_en) return ovr_data;
        if (a == 32'h0) return 32'h2008_FFFF;
        return {8'h3C, a[25:2]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    // One clock: observe IF/ID on the falling edge, then drive controls and the memory response.
    task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc, input logic rst);
        logic        ack_d;
        logic [31:0] a;
        sb_ent_t     e;
        @(negedge clock);
        if (prev_rst) begin
            check("rst_valid", {31'h0, id_valid}, 32'h0);
            check("rst_instr", id_instr, 32'h0);
            check("rst_pc4", id_pc4, 32'h0);
            check("rst_req", {31'h0, imem.req}, 32'h0);
        end else if (prev_rd) begin
            check("redirect_flush", {31'h0, id_valid}, 32'h0);
        end else if (prev_hold) begin
            check("hold_valid", {31'h0, id_valid}, 32'h1);
            check("hold_instr", id_instr, held_instr);
            check("hold_pc4", id_pc4, held_pc4);
        end else if (id_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_valid", {31'h0, id_valid}, 32'h0);
            end else begin
                e = sb_q.pop_front();
                check("id_instr", id_instr, e.instr);
                check("id_pc4", id_pc4, e.pc4);
                check("id_imm", {16'h0, id_imm}, {16'h0, e.instr[15:0]});
                held_instr = e.instr;
                held_pc4   = e.pc4;
            end
        end
        prev_hold = !rst && !rd && st && id_valid;
        prev_rd   = rd && !rst;
        prev_rst  = rst;

        reset       = rst;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        a     = imem.addr;
        ack_d = 1'b0;
        if (rst) begin
            sb_q.delete();
            exp_pc   = RESET_PC;
            draining = 1'b0;
            wait_cnt = 0;
            prev_req = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (imem.req) begin
                if (prev_req && !prev_ack) check("req_stable_addr", a, prev_addr);
                else if (!draining) check("fetch_addr", a, exp_pc);
                if (wait_cnt + 1 >= lat) begin
                    ack_d    = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
                if (ack_d && !rd && !draining) begin
                    sb_q.push_back('{mem_word(a), a + 32'd4});
                    exp_pc = a + 32'd4;
                end
            end else begin
                if (prev_req && !prev_ack) check("req_dropped", {31'h0, imem.req}, 32'h1);
                ack_d = spur;
            end
            if (rd) begin
                sb_q.delete();
                exp_pc = {rpc[31:2], 2'b00};
            end
            if (imem.req && ack_d) draining = 1'b0;
            if (rd && imem.req && !ack_d) draining = 1'b1;
            prev_req  = imem.req;
            prev_ack  = ack_d;
            prev_addr = a;
        end
        imem.ack   = ack_d;
        imem.rdata = mem_word(a);
    endtask

    initial begin
        int pulses;
        logic st, rd;
        imem.ack   = 1'b0;
        imem.rdata = '0;

        // Reset, then a same-cycle ack at address 0
        repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("t1_instr", id_instr, 32'h2008_FFFF);
        check("t1_imm", {16'h0, id_imm}, 32'h0000_FFFF);
        check("t1_pc4", id_pc4, 32'd4);
        check("t1_addr", imem.addr, 32'd4);

        // Three-cycle memory latency
        lat    = 3;
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
            if (id_valid) pulses++;
        end
        check("t2_pulses", 32'(pulses), 32'd3);

        // Stall four cycles; the next word lands in the skid buffer
        lat      = 1;
        ovr_en   = 1'b1;
        ovr_data = 32'h8C0A_0004;
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        ovr_en = 1'b0;
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        spur = 1'b1;
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        spur = 1'b0;
        check("t3_req_skid", {31'h0, imem.req}, 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        lat = 3;
        cycle(1'b0, 1'b1, 32'h0000_0103, 1'b0);
        check("t3_skid_instr", held_instr, 32'h8C0A_0004);

        // Redirect with a pending request; its late ack must be drained
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        lat = 1;
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("t4_target_addr", imem.addr, 32'h0000_0100);

        // Redirect and ack together while stalled
        cycle(1'b1, 1'b1, 32'h0000_0200, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("t5_valid", {31'h0, id_valid}, 32'h0);
        check("t5_addr", imem.addr, 32'h0000_0200);

        // PC+4 wraps at the top of the address space
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check("t6_pc4_wrap", id_pc4, 32'h0000_0000);
        check("t6_addr_wrap", imem.addr, 32'h0000_0000);

        // Reset while the skid buffer is full
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("t7_refetch", id_instr, 32'h2008_FFFF);

        // Mixed random traffic
        for (int i = 0; i < 400; i++) begin
            st   = ($urandom_range(0, 9) < 3);
            rd   = ($urandom_range(0, 19) == 0);
            spur = $urandom_range(0, 1) == 1;
            if (wait_cnt == 0) lat = $urandom_range(1, 3);
            cycle(st, rd, $urandom, 1'b0);
        end
        spur = 1'b0;
        lat  = 1;
        repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
